shift_add_scaler: RTL and testbench

- Iterative constant-coefficient scaler: result = sum over NTERMS of ±(data_in >> shamt_i). This is the parametrised successor to the two-term combinational barrel shifter.
- Evaluates one term per clock, using a single shifter and accumulator.
- Sits between a sample source and sink. Valid/ready handshake on both sides.
- Coefficients are captured per transaction.

---
 rtl/shift_add_pkg.sv | 20 ++
 rtl/shift_add_scaler_shift_term.sv | 29 ++
 rtl/shift_add_scaler.sv | 125 ++++++++++++
 tb/tb_shift_add_scaler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_pkg.sv
// Shared definitions for the iterative shift-add scaler: FSM encoding,
// accumulator sizing and the shift-amount slice helper.
package shift_add_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Signed accumulator wide enough that NTERMS terms of either sign can
    // never overflow internally (one sign bit plus one guard bit).
    function automatic int ACCW(input int width, input int nterms);
        return width + $clog2(nterms) + 2;
    endfunction

    // Low bit of term idx's shift amount inside the packed shamt bus.
    function automatic int shamt_lo(input int idx, input int shw);
        return idx * shw;
    endfunction

endpackage

// File: rtl/shift_add_scaler_shift_term.sv
// Single shared term evaluator: zero-filled right shift of the operand,
// widened to the accumulator width and optionally negated or suppressed.
import shift_add_pkg::*;

module shift_term #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4,
    parameter int AW    = 20
) (
    input  logic [WIDTH-1:0]     data,
    input  logic [SHW-1:0]       shamt,
    input  logic                 en,
    input  logic                 neg,
    output logic signed [AW-1:0] term
);

    logic [AW-1:0] mag;

    assign mag = AW'(data >> shamt);

    // Disabled terms contribute zero; enabled ones add or subtract the magnitude.
    always_comb begin
        term = '0;
        if (en) begin
            term = neg ? -signed'(mag) : signed'(mag);
        end
    end

endmodule

// File: rtl/shift_add_scaler.sv
// shift_add_scaler: result = sum over NTERMS of +/-(data_in >> shamt_i),
// evaluated one term per clock with a single shifter and accumulator.
// Optional feature macro SHIFT_ADD_SCALER_SAT_EN clamps the final result
// to [0, 2^WIDTH-1] instead of truncating modulo 2^WIDTH.
import shift_add_pkg::*;

module shift_add_scaler #(
    parameter int WIDTH  = 16,
    parameter int NTERMS = 4,
    parameter int SHW    = $clog2(WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        data_in,
    input  logic [NTERMS*SHW-1:0]   shamt,
    input  logic [NTERMS-1:0]       neg,
    input  logic [NTERMS-1:0]       term_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        shifted,
    output logic                    busy
);

    localparam int AW   = ACCW(WIDTH, NTERMS);
    localparam int IDXW = (NTERMS > 1) ? $clog2(NTERMS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NTERMS - 1);

    logic [1:0]             state_reg;
    logic [WIDTH-1:0]       data_reg;
    logic [NTERMS*SHW-1:0]  shamt_reg;
    logic [NTERMS-1:0]      neg_reg;
    logic [NTERMS-1:0]      en_reg;
    logic signed [AW-1:0]   acc_reg;
    logic [IDXW-1:0]        idx_reg;
    logic [WIDTH-1:0]       result_reg;

    logic [SHW-1:0]         shamt_arr [NTERMS];
    logic signed [AW-1:0]   term_val;
    logic signed [AW-1:0]   acc_next;
    logic [WIDTH-1:0]       result_next;

    // Unpack the captured shift amounts so the active term is a plain index.
    for (genvar gi = 0; gi < NTERMS; gi++) begin : g_shamt
        assign shamt_arr[gi] = shamt_reg[shamt_lo(gi, SHW) +: SHW];
    end

    shift_term #(
        .WIDTH (WIDTH),
        .SHW   (SHW),
        .AW    (AW)
    ) u_term (
        .data  (data_reg),
        .shamt (shamt_arr[idx_reg]),
        .en    (en_reg[idx_reg]),
        .neg   (neg_reg[idx_reg]),
        .term  (term_val)
    );

    assign acc_next = acc_reg + term_val;

    // Map the final signed sum onto the unsigned output range.
    always_comb begin
`ifdef SHIFT_ADD_SCALER_SAT_EN
        if (acc_next[AW-1]) begin
            result_next = '0;
        end else if (|acc_next[AW-2:WIDTH]) begin
            result_next = '1;
        end else begin
            result_next = acc_next[WIDTH-1:0];
        end
`else
        result_next = acc_next[WIDTH-1:0];
`endif
    end

    // FSM, operand capture and one-term-per-cycle accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            data_reg   <= '0;
            shamt_reg  <= '0;
            neg_reg    <= '0;
            en_reg     <= '0;
            acc_reg    <= '0;
            idx_reg    <= '0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        data_reg  <= data_in;
                        shamt_reg <= shamt;
                        neg_reg   <= neg;
                        en_reg    <= term_en;
                        acc_reg   <= '0;
                        idx_reg   <= '0;
                        state_reg <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_reg <= acc_next;
                    idx_reg <= idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        result_reg <= result_next;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == ACCUM) || (state_reg == DONE);
    assign shifted   = result_reg;

endmodule

// File: tb/tb_shift_add_scaler.sv
// Self-checking bench for shift_add_scaler (WIDTH=16, NTERMS=4).
// Expected results are queued when a request is accepted and compared
// when the DUT hands a result to the sink.
module tb_shift_add_scaler;

    localparam int WIDTH  = 16;
    localparam int NTERMS = 4;
    localparam int SHW    = 4;
`ifdef SHIFT_ADD_SCALER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [WIDTH-1:0]       data_in = '0;
    logic [NTERMS*SHW-1:0]  shamt = '0;
    logic [NTERMS-1:0]      neg = '0;
    logic [NTERMS-1:0]      term_en = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [WIDTH-1:0]       shifted;
    logic                   busy;

    int checks = 0;
    int fails  = 0;
    logic [WIDTH-1:0] exp_q [$];

    typedef struct {
        logic [15:0] data;
        logic [15:0] sh;
        logic [3:0]  ng;
        logic [3:0]  en;
        logic [15:0] exp_mod;
        logic [15:0] exp_sat;
    } vec_t;

    vec_t vecs [9];

    shift_add_scaler #(
        .WIDTH  (WIDTH),
        .NTERMS (NTERMS),
        .SHW    (SHW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .shamt     (shamt),
        .neg       (neg),
        .term_en   (term_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .shifted   (shifted),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Plain integer reference: sum of signed terms, then truncate or clamp.
    function automatic logic [15:0] model(input logic [15:0] d, input logic [15:0] sh,
                                          input logic [3:0] ng, input logic [3:0] en);
        longint s = 0;
        longint t;
        for (int i = 0; i < NTERMS; i++) begin
            if (en[i]) begin
                t = longint'(d >> sh[i*SHW +: SHW]);
                s = ng[i] ? s - t : s + t;
            end
        end
        if (SAT) begin
            if (s < 0) return 16'h0000;
            if (s > 65535) return 16'hFFFF;
        end
        return 16'(s);
    endfunction

    // Sink-side scoreboard: compare every handed-off result with the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: got %0h expected none", shifted);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (shifted !== e) begin
                    fails++;
                    $display("FAIL result: got %0h expected %0h", shifted, e);
                end else begin
                    $display("txn result %0h ok", shifted);
                end
            end
        end
    end

    task automatic accept(input logic [15:0] d, input logic [15:0] sh, input logic [3:0] ng,
                          input logic [3:0] en, input logic [15:0] expv, input bit push);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        check("in_ready_before_accept", in_ready, 1);
        data_in  = d;
        shamt    = sh;
        neg      = ng;
        term_en  = en;
        in_valid = 1'b1;
        if (push) exp_q.push_back(expv);
        step();
        in_valid = 1'b0;
    endtask

    // Latency counted in cycles from the accepting cycle to the first DONE cycle.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        check("out_valid_timeout", out_valid, 1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [15:0] d, sh, e;
        logic [3:0] ng, en;

        vecs[0] = '{16'd128,  16'h0002, 4'b0000, 4'b0001, 16'd32,    16'd32};
        vecs[1] = '{16'd9,    16'h0031, 4'b0000, 4'b0011, 16'd5,     16'd5};
        vecs[2] = '{16'd128,  16'h0020, 4'b0010, 4'b0011, 16'd96,    16'd96};
        vecs[3] = '{16'd16,   16'h0002, 4'b0010, 4'b0011, 16'hFFF4,  16'h0000};
        vecs[4] = '{16'hFFFF, 16'h0000, 4'b0000, 4'b1111, 16'hFFFC,  16'hFFFF};
        vecs[5] = '{16'h8000, 16'h000F, 4'b0000, 4'b0001, 16'd1,     16'd1};
        vecs[6] = '{16'd1234, 16'h0000, 4'b1111, 4'b0000, 16'd0,     16'd0};
        vecs[7] = '{16'd100,  16'h0010, 4'b0001, 4'b0010, 16'd50,    16'd50};
        vecs[8] = '{16'd1000, 16'h4321, 4'b0100, 4'b1111, 16'd687,   16'd687};

        // Reset state
        step();
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_shifted", shifted, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        step();

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            e = SAT ? vecs[i].exp_sat : vecs[i].exp_mod;
            accept(vecs[i].data, vecs[i].sh, vecs[i].ng, vecs[i].en, e, 1'b1);
            check("busy_in_accum", busy, 1);
            check("in_ready_in_accum", in_ready, 0);
            wait_valid(lat);
            if (i == 0) check("latency", lat, NTERMS + 1);
            drain();
        end

        // Random transactions against the integer model
        for (int i = 0; i < 6; i++) begin
            d  = 16'($urandom);
            sh = 16'($urandom);
            ng = 4'($urandom);
            en = 4'($urandom);
            accept(d, sh, ng, en, model(d, sh, ng, en), 1'b1);
            wait_valid(lat);
            check("random_latency", lat, NTERMS + 1);
            drain();
        end

        // Backpressure: result held for 7 cycles, new requests ignored
        accept(16'd128, 16'h0002, 4'b0000, 4'b0001, 16'd32, 1'b1);
        wait_valid(lat);
        for (int c = 0; c < 7; c++) begin
            in_valid = c[0];
            data_in  = 16'h1111;
            term_en  = 4'b1111;
            check("hold_out_valid", out_valid, 1);
            check("hold_shifted", shifted, 32);
            check("hold_in_ready", in_ready, 0);
            step();
        end
        in_valid = 1'b0;
        drain();
        check("after_hold_in_ready", in_ready, 1);
        step();
        check("ignored_req_busy", busy, 0);
        check("ignored_req_out_valid", out_valid, 0);

        // Inputs changed during ACCUM must not affect the result
        accept(16'd9, 16'h0031, 4'b0000, 4'b0011, 16'd5, 1'b1);
        data_in = 16'hAAAA;
        shamt   = 16'h0000;
        neg     = 4'b1111;
        term_en = 4'b1111;
        wait_valid(lat);
        drain();

        // Reset during the second ACCUM cycle aborts the transaction
        accept(16'd128, 16'h0020, 4'b0010, 4'b0011, 16'd0, 1'b0);
        step();
        rst = 1'b1;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_shifted", shifted, 0);
        check("abort_busy", busy, 0);
        step();
        rst = 1'b0;
        step();
        check("abort_no_result", out_valid, 0);
        accept(16'd128, 16'h0020, 4'b0010, 4'b0011, 16'd96, 1'b1);
        wait_valid(lat);
        check("post_abort_latency", lat, NTERMS + 1);
        drain();

        step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
